// File: rtl/i2c_reg_sequencer.sv
// i2c_reg_sequencer: drives i2c_master_regs over the register bus to run one-byte I2C transfers for a client.
module i2c_reg_sequencer #(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 8,
  parameter logic [7:0] PRESCALE = 8'h04,
  parameter int ADDR_PRE = 0,
  parameter int ADDR_CTR = 2,
  parameter int ADDR_TXR = 3,
  parameter int ADDR_CR = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Req,
  input  logic              Rnw,
  input  logic [6:0]        Dev_addr,
  input  logic [7:0]        Wdata,
  output logic              Ack,
  output logic [7:0]        Rdata,
  output logic [1:0]        Err,
  output logic              Busy,
  output logic [AWIDTH-1:0] Addr,
  output logic [DWIDTH-1:0] Dout,
  input  logic [DWIDTH-1:0] Din,
  output logic              Wr
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [4:0] {
    INIT_PRE, INIT_CTR, IDLE, TX_ADDR, CMD_ADDR, POLL_A, EVAL_A, TX_DATA, CMD_DATA,
    POLL_D, EVAL_D, RD_RXR, LATCH_RXR, ALACK, ABORT, POLL_S, EVAL_S, DONE
  } state_t;
  state_t state, nxt;
  logic run, rnw_q;
  logic [6:0] dev_q;
  logic [7:0] wdata_q;
  logic [CW-1:0] cnt;
  logic al, tip, rxack, to, ev;
  assign al = Din[5];
  assign tip = Din[1];
  assign rxack = Din[7];
  assign to = cnt == CW'(TIMEOUT);
  assign ev = state inside {EVAL_A, EVAL_D, EVAL_S};
  assign Ack = state == DONE;
  assign Busy = !(state inside {INIT_PRE, INIT_CTR, IDLE, DONE});
  // run keeps the init write off the bus while reset is held
  always_comb begin
    nxt = state;
    Wr = 1'b0;
    Addr = '0;
    Dout = '0;
    case (state)
      INIT_PRE: begin
        Wr = run;
        Addr = run ? AWIDTH'(ADDR_PRE) : '0;
        Dout = run ? PRESCALE : '0;
        nxt = run ? INIT_CTR : INIT_PRE;
      end
      INIT_CTR: begin Wr = 1'b1; Addr = AWIDTH'(ADDR_CTR); Dout = 8'h80; nxt = IDLE; end
      IDLE: nxt = Req ? TX_ADDR : IDLE;
      TX_ADDR: begin Wr = 1'b1; Addr = AWIDTH'(ADDR_TXR); Dout = {dev_q, rnw_q}; nxt = CMD_ADDR; end
      CMD_ADDR: begin Wr = 1'b1; Addr = AWIDTH'(ADDR_CR); Dout = 8'h90; nxt = POLL_A; end
      POLL_A: begin Addr = AWIDTH'(ADDR_CR); nxt = EVAL_A; end
      EVAL_A: nxt = al ? ALACK : tip ? (to ? ABORT : POLL_A) : rxack ? ABORT : rnw_q ? CMD_DATA : TX_DATA;
      TX_DATA: begin Wr = 1'b1; Addr = AWIDTH'(ADDR_TXR); Dout = wdata_q; nxt = CMD_DATA; end
      CMD_DATA: begin Wr = 1'b1; Addr = AWIDTH'(ADDR_CR); Dout = rnw_q ? 8'h68 : 8'h50; nxt = POLL_D; end
      POLL_D: begin Addr = AWIDTH'(ADDR_CR); nxt = EVAL_D; end
      EVAL_D: nxt = al ? ALACK : tip ? (to ? ABORT : POLL_D) : rnw_q ? RD_RXR : DONE;
      RD_RXR: begin Addr = AWIDTH'(ADDR_TXR); nxt = LATCH_RXR; end
      LATCH_RXR: nxt = DONE;
      ALACK: begin Wr = 1'b1; Addr = AWIDTH'(ADDR_CR); Dout = 8'h01; nxt = DONE; end
      ABORT: begin Wr = 1'b1; Addr = AWIDTH'(ADDR_CR); Dout = 8'h40; nxt = POLL_S; end
      POLL_S: begin Addr = AWIDTH'(ADDR_CR); nxt = EVAL_S; end
      EVAL_S: nxt = al ? ALACK : (tip && !to) ? POLL_S : DONE;
      DONE: nxt = IDLE;
      default: nxt = INIT_PRE;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state <= INIT_PRE;
      run <= 1'b0;
      cnt <= '0;
      rnw_q <= 1'b0;
      dev_q <= '0;
      wdata_q <= '0;
      Rdata <= '0;
      Err <= '0;
    end else begin
      state <= nxt;
      run <= 1'b1;
      cnt <= (ev && tip && !al && !to) ? cnt + CW'(1) : ev ? '0 : cnt;
      if (state == IDLE && Req) begin
        rnw_q <= Rnw;
        dev_q <= Dev_addr;
        wdata_q <= Wdata;
        Rdata <= '0;
        Err <= '0;
      end
      if (state == LATCH_RXR) Rdata <= Din;
      // the stop phase never overwrites the code that caused the abort
      if (state == EVAL_A || state == EVAL_D)
        Err <= al ? 2'd2 : tip ? (to ? 2'd3 : Err) : (rxack && (state == EVAL_A || !rnw_q)) ? 2'd1 : Err;
    end
  end
endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// tb_i2c_reg_sequencer: scoreboard bench with a register-file model answering SR/RXR reads.
module tb_i2c_reg_sequencer;
  logic clk = 0, rst_n = 0, req = 0, rnw = 0;
  logic [6:0] dev_addr = 0;
  logic [7:0] wdata = 0, din = 0;
  logic ack, busy, wr;
  logic [7:0] rdata, dout;
  logic [1:0] err;
  logic [2:0] addr;
  int vectors = 0, miscompares = 0;
  logic [10:0] exp_wr[$];
  logic [9:0] exp_ack[$];
  logic hold_tip = 0;
  int tip_n = 5, pc = 0, polls_at_stop = 0;
  logic [7:0] sr_a = 0, sr_d = 0, rxr = 0, phase = 0;
  always #5 clk = ~clk;
  i2c_reg_sequencer #(.TIMEOUT(7)) dut (
    .Clk(clk), .Rst_n(rst_n), .Req(req), .Rnw(rnw), .Dev_addr(dev_addr), .Wdata(wdata),
    .Ack(ack), .Rdata(rdata), .Err(err), .Busy(busy), .Addr(addr), .Dout(dout), .Din(din), .Wr(wr)
  );
  // registered-read model of the I2C core registers
  always @(posedge clk) begin
    if (wr && addr == 3'd4) begin
      phase <= dout;
      pc <= 0;
      if (dout == 8'h40) polls_at_stop <= pc;
    end else if (!wr && addr == 3'd4) begin
      pc <= pc + 1;
      din <= (hold_tip || pc < tip_n) ? 8'h02 : phase == 8'h90 ? sr_a :
             (phase == 8'h50 || phase == 8'h68) ? sr_d : 8'h00;
    end else if (!wr && addr == 3'd3) din <= rxr;
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask
  always @(negedge clk) begin
    if (wr) begin
      if (exp_wr.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got addr %0d data %h expected none", addr, dout);
      end else check("bus_write", {21'b0, addr, dout}, {21'b0, exp_wr.pop_front()});
    end
    if (ack) begin
      if (exp_ack.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_ack: got rdata %h err %0d expected none", rdata, err);
      end else check("ack_busy_rdata_err", {21'b0, busy, rdata, err}, {22'b0, exp_ack.pop_front()});
    end
  end
  task automatic do_req(input logic r, input logic [6:0] a, input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    req = 1; rnw = r; dev_addr = a; wdata = d;
    repeat (3) @(negedge clk);
    check("busy_after_accept", {31'b0, busy}, 32'd1);
    while (!ack && n < 500) begin @(negedge clk); n++; end
    if (!ack) begin
      vectors++;
      miscompares++;
      $display("FAIL ack_timeout: got no ack expected ack within 500 cycles");
    end
    req = 0;
    @(negedge clk);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("reset_outputs", {8'b0, ack, rdata, err, busy, addr, dout, wr}, 32'd0);
    exp_wr.push_back({3'd0, 8'h04}); exp_wr.push_back({3'd2, 8'h80});
    rst_n = 1;
    repeat (4) @(negedge clk);
    check("idle_busy", {31'b0, busy}, 32'd0);
    // write
    exp_wr.push_back({3'd3, 8'hA0}); exp_wr.push_back({3'd4, 8'h90});
    exp_wr.push_back({3'd3, 8'hA5}); exp_wr.push_back({3'd4, 8'h50});
    exp_ack.push_back({8'h00, 2'd0});
    do_req(0, 7'h50, 8'hA5);
    // read: RxACK=1 after the NACKed read byte is expected and ignored
    sr_d = 8'h80; rxr = 8'h3C;
    exp_wr.push_back({3'd3, 8'hA1}); exp_wr.push_back({3'd4, 8'h90}); exp_wr.push_back({3'd4, 8'h68});
    exp_ack.push_back({8'h3C, 2'd0});
    do_req(1, 7'h50, 8'h00);
    repeat (2) @(negedge clk);
    check("rdata_hold", {22'b0, rdata, err}, {22'b0, 8'h3C, 2'd0});
    // address NACK
    sr_a = 8'h80; sr_d = 8'h00;
    exp_wr.push_back({3'd3, 8'h42}); exp_wr.push_back({3'd4, 8'h90}); exp_wr.push_back({3'd4, 8'h40});
    exp_ack.push_back({8'h00, 2'd1});
    do_req(0, 7'h21, 8'h77);
    // arbitration lost, reported together with TIP to exercise priority
    sr_a = 8'h22;
    exp_wr.push_back({3'd3, 8'h42}); exp_wr.push_back({3'd4, 8'h90}); exp_wr.push_back({3'd4, 8'h01});
    exp_ack.push_back({8'h00, 2'd2});
    do_req(0, 7'h21, 8'h77);
    // timeout in both the address phase and the stop phase
    sr_a = 8'h00; hold_tip = 1;
    exp_wr.push_back({3'd3, 8'h1E}); exp_wr.push_back({3'd4, 8'h90}); exp_wr.push_back({3'd4, 8'h40});
    exp_ack.push_back({8'h00, 2'd3});
    do_req(0, 7'h0F, 8'h11);
    check("addr_phase_polls", polls_at_stop, 32'd8);
    check("stop_phase_polls", pc, 32'd8);
    // reset in the middle of polling
    exp_wr.push_back({3'd3, 8'hA0}); exp_wr.push_back({3'd4, 8'h90});
    @(negedge clk);
    req = 1; rnw = 0; dev_addr = 7'h50; wdata = 8'h99;
    repeat (6) @(negedge clk);
    check("busy_mid_poll", {31'b0, busy}, 32'd1);
    req = 0; rst_n = 0;
    @(negedge clk);
    check("mid_reset_outputs", {8'b0, ack, rdata, err, busy, addr, dout, wr}, 32'd0);
    hold_tip = 0;
    exp_wr.push_back({3'd0, 8'h04}); exp_wr.push_back({3'd2, 8'h80});
    rst_n = 1;
    repeat (6) @(negedge clk);
    check("wr_queue_drained", exp_wr.size(), 32'd0);
    check("ack_queue_drained", exp_ack.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end
endmodule
